mux_arb_nch: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking on every input channel and on the output. It selects one channel per cycle, either from an explicit select or by arbitration among valid channels, and captures the word in a single output register stage. It replaces hard-wired 8:1 word muxes wherever the source is a stream rather than a static operand, e.g. writeback/forwarding source merging and multi-requester buses.

---
 rtl/mux_arb_nch_if.sv | 47 ++++
 rtl/mux_arb_nch.sv | 152 +++++++++++++++
 tb/tb_mux_arb_nch.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nch_if.sv
// ---------------------------------------------------------------------------
// mux_arb_nch_if
//
// Handshake/bus bundle for mux_arb_nch: NCH valid/ready input channels of
// WIDTH bits each, the select/arbitration controls, and one valid/ready
// output channel that carries the selected word plus its source index.
//
// Signals:
//   in_data   [NCH*WIDTH]  channel i occupies bits [i*WIDTH +: WIDTH]
//   in_valid  [NCH]        channel i presents a word
//   in_ready  [NCH]        channel i word accepted this cycle
//   mode                   0 = explicit select, 1 = arbitrate
//   sel       [SELW]       channel index used when mode = 0
//   out_data  [WIDTH]      registered selected word
//   out_ch    [SELW]       registered index of the producing channel
//   out_valid              out_data/out_ch hold a word
//   out_ready              downstream accepts the output word
//
// Modports:
//   master - the environment (sources and sink) around the mux
//   slave  - the mux itself
// ---------------------------------------------------------------------------
interface mux_arb_nch_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
);
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_arb_nch.sv
// ---------------------------------------------------------------------------
// mux_arb_nch
//
// N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking.
// Each cycle at most one input channel is chosen, either by explicit select
// (mode = 0) or by arbitration among valid channels (mode = 1), and its word
// is captured into a single output register stage together with its index.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_arb_nch_if.slave (in_data/in_valid/in_ready, mode, sel,
//          out_data/out_ch/out_valid/out_ready)
//
// Configuration macro:
//   MUX_ARB_NCH_RR_EN  defined   -> mode = 1 is round-robin from an internal
//                                   pointer that moves past each accepted
//                                   channel (in either mode).
//                      undefined -> mode = 1 is fixed priority, lowest valid
//                                   index wins; no pointer exists.
// ---------------------------------------------------------------------------
module mux_arb_nch #(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arb_nch_if.slave bus
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic             load_en;
    logic             found;
    logic [SELW-1:0]  chosen;
    logic [WIDTH-1:0] chosen_word;
    logic [NCH-1:0]   chosen_onehot;
    logic             accept;

`ifdef MUX_ARB_NCH_RR_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
`endif

    // The register may take a new word when empty or when it drains this cycle.
    assign load_en = !out_valid_q || bus.out_ready;
    assign accept  = load_en && found;

    // Channel selection. All loops use constant indices so that an
    // out-of-range sel (non-power-of-2 NCH) simply matches nothing.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // otherwise paths that leave it unassigned would infer a latch.
        found         = 1'b0;
        chosen        = '0;
        chosen_word   = '0;
        chosen_onehot = '0;
        if (!bus.mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(bus.sel) == i && bus.in_valid[i]) begin
                    found            = 1'b1;
                    chosen           = SELW'(i);
                    chosen_word      = bus.in_data[i*WIDTH +: WIDTH];
                    chosen_onehot[i] = 1'b1;
                end
            end
        end else begin
`ifdef MUX_ARB_NCH_RR_EN
            // Rotated search as two passes: ptr..NCH-1, then 0..ptr-1.
            for (int i = 0; i < NCH; i++) begin
                if (!found && i >= int'(ptr_q) && bus.in_valid[i]) begin
                    found            = 1'b1;
                    chosen           = SELW'(i);
                    chosen_word      = bus.in_data[i*WIDTH +: WIDTH];
                    chosen_onehot[i] = 1'b1;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!found && i < int'(ptr_q) && bus.in_valid[i]) begin
                    found            = 1'b1;
                    chosen           = SELW'(i);
                    chosen_word      = bus.in_data[i*WIDTH +: WIDTH];
                    chosen_onehot[i] = 1'b1;
                end
            end
`else
            for (int i = 0; i < NCH; i++) begin
                if (!found && bus.in_valid[i]) begin
                    found            = 1'b1;
                    chosen           = SELW'(i);
                    chosen_word      = bus.in_data[i*WIDTH +: WIDTH];
                    chosen_onehot[i] = 1'b1;
                end
            end
`endif
        end
    end

    assign bus.in_ready = load_en ? chosen_onehot : '0;

    // Next-state for the output register stage.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_data_d  = chosen_word;
            out_ch_d    = chosen;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_ARB_NCH_RR_EN
    // Pointer moves just past the accepted channel; explicit wrap handles
    // non-power-of-2 NCH.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (chosen == SELW'(NCH - 1)) ? '0 : chosen + SELW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef MUX_ARB_NCH_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_ARB_NCH_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_arb_nch.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_nch
//
// Directed bench for mux_arb_nch. Two instances share clk/rst_n: an 8-channel
// one for the main scenarios and a 5-channel one for out-of-range select and
// pointer wrap. Expected arbitration results follow MUX_ARB_NCH_RR_EN.
// ---------------------------------------------------------------------------
module tb_mux_arb_nch;

    localparam int WIDTH = 16;

`ifdef MUX_ARB_NCH_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    mux_arb_nch_if #(.WIDTH(WIDTH), .NCH(8), .SELW(3)) bus8 ();
    mux_arb_nch_if #(.WIDTH(WIDTH), .NCH(5), .SELW(3)) bus5 ();

    mux_arb_nch #(.WIDTH(WIDTH), .NCH(8), .SELW(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    mux_arb_nch #(.WIDTH(WIDTH), .NCH(5), .SELW(3)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data8(input logic [15:0] base);
        for (int i = 0; i < 8; i++) bus8.in_data[i*WIDTH +: WIDTH] = base + 16'(i);
    endtask

    task automatic set_data5(input logic [15:0] base);
        for (int i = 0; i < 5; i++) bus5.in_data[i*WIDTH +: WIDTH] = base + 16'(i);
    endtask

    task automatic test_reset();
        logic [19:0] exp_o;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        exp_o = {1'b0, 3'd0, 16'h0000};
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== exp_o) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, exp_o);
        end
        bus8.mode = 1'b0; bus8.sel = 3'd5; bus8.in_valid = 8'hFF; bus8.out_ready = 1'b1;
        set_data8(16'h1000);
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want %b", bus8.in_ready, 8'b0010_0000);
        end
        tick();
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== exp_o) begin
            n_err++;
            $display("FAIL reset_no_update: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, exp_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_select();
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL sel_in_ready: got %b want %b", bus8.in_ready, 8'b0010_0000);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'd5, 16'h1005}) begin
                n_err++;
                $display("FAIL sel_out[%0d]: got %h want %h", k, {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'd5, 16'h1005});
            end
            n_cmp++;
            if (bus8.in_ready !== 8'b0010_0000) begin
                n_err++;
                $display("FAIL sel_stream_ready[%0d]: got %b want %b", k, bus8.in_ready, 8'b0010_0000);
            end
        end
    endtask

    task automatic test_back_pressure();
        bus8.out_ready = 1'b0;
        set_data8(16'h2000);
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'h00) begin
            n_err++;
            $display("FAIL bp_in_ready: got %b want %b", bus8.in_ready, 8'h00);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({bus8.out_valid, bus8.out_ch, bus8.out_data, bus8.in_ready} !== {1'b1, 3'd5, 16'h1005, 8'h00}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got %h want %h", k, {bus8.out_valid, bus8.out_ch, bus8.out_data, bus8.in_ready}, {1'b1, 3'd5, 16'h1005, 8'h00});
            end
        end
        bus8.out_ready = 1'b1;
        set_data8(16'h3000);
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want %b", bus8.in_ready, 8'b0010_0000);
        end
        tick();
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'd5, 16'h3005}) begin
            n_err++;
            $display("FAIL bp_no_bubble: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'd5, 16'h3005});
        end
    endtask

    task automatic test_reset_mid_stall();
        set_data8(16'h1000);
        bus8.in_data[5*WIDTH +: WIDTH] = 16'h1234;
        tick();
        bus8.out_ready = 1'b0;
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL stall_load: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'd5, 16'h1234});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== 20'h0) begin
            n_err++;
            $display("FAIL stall_async_reset: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, 20'h0);
        end
        tick();
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== 20'h0) begin
            n_err++;
            $display("FAIL stall_reset_held: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, 20'h0);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus8.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release_no_edge: got %b want %b", bus8.out_valid, 1'b0);
        end
        tick();
        n_cmp++;
        if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL stall_first_accept: got %h want %h", {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'd5, 16'h1234});
        end
        bus8.out_ready = 1'b1;
        bus8.in_valid  = 8'h00;
        tick();
        n_cmp++;
        if (bus8.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_drain: got %b want %b", bus8.out_valid, 1'b0);
        end
    endtask

    task automatic test_round_robin();
        int exp_rr[5] = '{0, 3, 7, 0, 3};
        int e;
        // Short asynchronous pulse returns the pointer to 0.
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus8.mode = 1'b1; bus8.in_valid = 8'b1000_1001; bus8.out_ready = 1'b1;
        set_data8(16'h1000);
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'b0000_0001) begin
            n_err++;
            $display("FAIL rr_first_ready: got %b want %b", bus8.in_ready, 8'b0000_0001);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            e = RR ? exp_rr[k] : 0;
            n_cmp++;
            if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'(e), 16'h1000 + 16'(e)}) begin
                n_err++;
                $display("FAIL rr_grant[%0d]: got %h want %h", k, {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'(e), 16'h1000 + 16'(e)});
            end
        end
    endtask

    task automatic test_mode_switch();
        int e;
        bus8.in_valid = 8'hFF; bus8.sel = 3'd2; bus8.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus8.mode = (k % 2 == 1);
            // Explicit select gives 2; arbitration resumes just past it (3).
            e = (k % 2 == 0) ? 2 : (RR ? 3 : 0);
            #1;
            n_cmp++;
            if (bus8.in_ready !== (8'd1 << e)) begin
                n_err++;
                $display("FAIL ms_ready[%0d]: got %b want %b", k, bus8.in_ready, 8'd1 << e);
            end
            tick();
            n_cmp++;
            if ({bus8.out_valid, bus8.out_ch, bus8.out_data} !== {1'b1, 3'(e), 16'h1000 + 16'(e)}) begin
                n_err++;
                $display("FAIL ms_grant[%0d]: got %h want %h", k, {bus8.out_valid, bus8.out_ch, bus8.out_data}, {1'b1, 3'(e), 16'h1000 + 16'(e)});
            end
        end
        bus8.mode = 1'b0; bus8.in_valid = 8'b1111_1011;
        #1;
        n_cmp++;
        if (bus8.in_ready !== 8'h00) begin
            n_err++;
            $display("FAIL ms_sel_invalid_ready: got %b want %b", bus8.in_ready, 8'h00);
        end
        tick();
        n_cmp++;
        if (bus8.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ms_sel_invalid_out: got %b want %b", bus8.out_valid, 1'b0);
        end
    endtask

    task automatic test_non_pow2();
        int e;
        set_data5(16'h5000);
        bus5.mode = 1'b0; bus5.sel = 3'd6; bus5.in_valid = 5'b11111; bus5.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus5.in_ready !== 5'b00000) begin
            n_err++;
            $display("FAIL np2_sel6_ready: got %b want %b", bus5.in_ready, 5'b00000);
        end
        tick();
        n_cmp++;
        if (bus5.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL np2_sel6_out: got %b want %b", bus5.out_valid, 1'b0);
        end
        bus5.sel = 3'd7;
        #1;
        n_cmp++;
        if (bus5.in_ready !== 5'b00000) begin
            n_err++;
            $display("FAIL np2_sel7_ready: got %b want %b", bus5.in_ready, 5'b00000);
        end
        bus5.sel = 3'd3;
        #1;
        n_cmp++;
        if (bus5.in_ready !== 5'b01000) begin
            n_err++;
            $display("FAIL np2_sel3_ready: got %b want %b", bus5.in_ready, 5'b01000);
        end
        tick();
        n_cmp++;
        if ({bus5.out_valid, bus5.out_ch, bus5.out_data} !== {1'b1, 3'd3, 16'h5003}) begin
            n_err++;
            $display("FAIL np2_sel3_out: got %h want %h", {bus5.out_valid, bus5.out_ch, bus5.out_data}, {1'b1, 3'd3, 16'h5003});
        end
        // Pointer now sits at 4: round-robin grants 4 then wraps to 0.
        bus5.mode = 1'b1; bus5.in_valid = 5'b10001;
        e = RR ? 4 : 0;
        #1;
        n_cmp++;
        if (bus5.in_ready !== (5'd1 << e)) begin
            n_err++;
            $display("FAIL np2_arb_ready0: got %b want %b", bus5.in_ready, 5'd1 << e);
        end
        tick();
        n_cmp++;
        if ({bus5.out_valid, bus5.out_ch, bus5.out_data} !== {1'b1, 3'(e), 16'h5000 + 16'(e)}) begin
            n_err++;
            $display("FAIL np2_arb_grant0: got %h want %h", {bus5.out_valid, bus5.out_ch, bus5.out_data}, {1'b1, 3'(e), 16'h5000 + 16'(e)});
        end
        #1;
        n_cmp++;
        if (bus5.in_ready !== 5'b00001) begin
            n_err++;
            $display("FAIL np2_arb_ready1: got %b want %b", bus5.in_ready, 5'b00001);
        end
        tick();
        n_cmp++;
        if ({bus5.out_valid, bus5.out_ch, bus5.out_data} !== {1'b1, 3'd0, 16'h5000}) begin
            n_err++;
            $display("FAIL np2_arb_wrap: got %h want %h", {bus5.out_valid, bus5.out_ch, bus5.out_data}, {1'b1, 3'd0, 16'h5000});
        end
        bus5.in_valid = 5'b00000;
        #1;
        n_cmp++;
        if (bus5.in_ready !== 5'b00000) begin
            n_err++;
            $display("FAIL np2_idle_ready: got %b want %b", bus5.in_ready, 5'b00000);
        end
        tick();
        n_cmp++;
        if ({bus5.out_valid, bus5.out_ch, bus5.out_data} !== {1'b0, 3'd0, 16'h5000}) begin
            n_err++;
            $display("FAIL np2_idle_drain: got %h want %h", {bus5.out_valid, bus5.out_ch, bus5.out_data}, {1'b0, 3'd0, 16'h5000});
        end
    endtask

    initial begin
        bus8.in_data = '0; bus8.in_valid = '0; bus8.mode = 1'b0; bus8.sel = '0; bus8.out_ready = 1'b0;
        bus5.in_data = '0; bus5.in_valid = '0; bus5.mode = 1'b0; bus5.sel = '0; bus5.out_ready = 1'b0;
        test_reset();
        test_select();
        test_back_pressure();
        test_reset_mid_stall();
        test_round_robin();
        test_mode_switch();
        test_non_pow2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
